// File: rtl/idma_pkg.sv
// rtl/idma_pkg.sv - shared iDMA types: 2D request typedef macro and midend FSM state
//
// IDMA_TYPEDEF_ND_REQ_T(name, addr_t, len_t, rep_t, opt_t) declares a packed
// 2D request struct: length, src/dst base, src/dst stride, repetitions, opts.

`define IDMA_TYPEDEF_ND_REQ_T(req_t, addr_t, len_t, rep_t, opt_t) \
  typedef struct packed {                                         \
    len_t  length;                                                \
    addr_t src_addr;                                              \
    addr_t dst_addr;                                              \
    addr_t src_stride;                                            \
    addr_t dst_stride;                                            \
    rep_t  reps;                                                  \
    opt_t  opt;                                                   \
  } req_t;

package idma_pkg;

  // Issue FSM of the 2D midend
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } idma_2d_state_e;

endpackage

// File: rtl/idma_2d_midend_if.sv
// rtl/idma_2d_midend_if.sv - response-side handshake bundle of the 2D midend
//
// be_rsp_*  : 1D responses coming back from the backend
// nd_rsp_*  : aggregated 2D completion towards the requester
// master    : the side producing 1D responses and consuming completions
// slave     : the response tracker inside the midend

interface idma_2d_midend_if;
  logic be_rsp_valid;
  logic be_rsp_ready;
  logic be_rsp_error;
  logic be_rsp_last;
  logic nd_rsp_valid;
  logic nd_rsp_ready;
  logic nd_rsp_error;

  modport master (
    output be_rsp_valid, be_rsp_error, be_rsp_last, nd_rsp_ready,
    input  be_rsp_ready, nd_rsp_valid, nd_rsp_error
  );

  modport slave (
    input  be_rsp_valid, be_rsp_error, be_rsp_last, nd_rsp_ready,
    output be_rsp_ready, nd_rsp_valid, nd_rsp_error
  );
endinterface

// File: rtl/idma_2d_rsp_tracker.sv
// rtl/idma_2d_rsp_tracker.sv - outstanding-job counter and 2D completion aggregation
//
// clk_i, rst_i  : clock, synchronous active-high reset
// issue_i       : a 2D job was accepted this cycle
// can_accept_o  : fewer than NumOutstanding jobs in flight
// busy_o        : jobs outstanding or a completion pending
// rsp           : 1D response in, 2D completion out (slave side)

module idma_2d_rsp_tracker #(
  parameter int unsigned NumOutstanding = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_i,
  output logic                    can_accept_o,
  output logic                    busy_o,
  idma_2d_midend_if.slave         rsp
);
  localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t MaxCnt = cnt_t'(NumOutstanding);

  cnt_t cnt_q, cnt_d;
  logic sticky_q, sticky_d;
  logic valid_q, valid_d;
  logic error_q, error_d;
  logic rsp_hs, job_done;

  // A pending completion only blocks new responses while it is not being taken.
  assign rsp.be_rsp_ready = ~valid_q | rsp.nd_rsp_ready;
  assign rsp.nd_rsp_valid = valid_q;
  assign rsp.nd_rsp_error = error_q;
  assign can_accept_o     = (cnt_q < MaxCnt);
  assign busy_o           = (cnt_q != '0) | valid_q;

  assign rsp_hs   = rsp.be_rsp_valid & rsp.be_rsp_ready;
  assign job_done = rsp_hs & rsp.be_rsp_last;

  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    valid_d  = valid_q;
    error_d  = error_q;

    // Guard against a stray last response underflowing the counter.
    case ({issue_i, job_done && (cnt_q != '0)})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase

    if (valid_q && rsp.nd_rsp_ready) valid_d = 1'b0;

    if (job_done) begin
      valid_d  = 1'b1;
      error_d  = sticky_q | rsp.be_rsp_error;
      sticky_d = 1'b0;
    end else if (rsp_hs) begin
      sticky_d = sticky_q | rsp.be_rsp_error;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end
endmodule

// File: rtl/idma_2d_midend.sv
// rtl/idma_2d_midend.sv - splits one 2D iDMA transfer into a stream of 1D backend requests
//
// clk_i, rst_i      : clock, synchronous active-high reset
// nd_req_*          : 2D request (length, src/dst base, strides, reps, opts)
// be_req_*          : 1D request to the backend, be_last_o on the final one
// be_rsp_*          : 1D responses from the backend
// nd_rsp_*          : one 2D completion per job, error accumulated over the job
// busy_o            : issuing, jobs outstanding or completion pending

module idma_2d_midend
  import idma_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned TFLenWidth     = 32,
  parameter int unsigned RepWidth       = 32,
  parameter int unsigned OptWidth       = 64,
  parameter int unsigned NumOutstanding = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  nd_req_valid_i,
  output logic                  nd_req_ready_o,
  input  logic [TFLenWidth-1:0] nd_length_i,
  input  logic [AddrWidth-1:0]  nd_src_addr_i,
  input  logic [AddrWidth-1:0]  nd_dst_addr_i,
  input  logic [AddrWidth-1:0]  nd_src_stride_i,
  input  logic [AddrWidth-1:0]  nd_dst_stride_i,
  input  logic [RepWidth-1:0]   nd_reps_i,
  input  logic [OptWidth-1:0]   nd_opt_i,
  output logic                  be_req_valid_o,
  input  logic                  be_req_ready_i,
  output logic [TFLenWidth-1:0] be_length_o,
  output logic [AddrWidth-1:0]  be_src_addr_o,
  output logic [AddrWidth-1:0]  be_dst_addr_o,
  output logic [OptWidth-1:0]   be_opt_o,
  output logic                  be_last_o,
  input  logic                  be_rsp_valid_i,
  output logic                  be_rsp_ready_o,
  input  logic                  be_rsp_error_i,
  input  logic                  be_rsp_last_i,
  output logic                  nd_rsp_valid_o,
  input  logic                  nd_rsp_ready_i,
  output logic                  nd_rsp_error_o,
  output logic                  busy_o
);
  typedef logic [AddrWidth-1:0]  addr_t;
  typedef logic [TFLenWidth-1:0] len_t;
  typedef logic [RepWidth-1:0]   rep_t;
  typedef logic [OptWidth-1:0]   opt_t;
  `IDMA_TYPEDEF_ND_REQ_T(nd_req_t, addr_t, len_t, rep_t, opt_t)

  // src_addr/dst_addr track the current 1D addresses; reps counts what is left.
  idma_2d_state_e state_q, state_d;
  nd_req_t        job_q, job_d;
  logic           can_accept, trk_busy, nd_ready, nd_hs;

  idma_2d_midend_if rsp_if ();

  assign rsp_if.be_rsp_valid = be_rsp_valid_i;
  assign rsp_if.be_rsp_error = be_rsp_error_i;
  assign rsp_if.be_rsp_last  = be_rsp_last_i;
  assign rsp_if.nd_rsp_ready = nd_rsp_ready_i;
  assign be_rsp_ready_o      = rsp_if.be_rsp_ready;
  assign nd_rsp_valid_o      = rsp_if.nd_rsp_valid;
  assign nd_rsp_error_o      = rsp_if.nd_rsp_error;

  idma_2d_rsp_tracker #(
    .NumOutstanding (NumOutstanding)
  ) i_rsp_tracker (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .issue_i      (nd_hs),
    .can_accept_o (can_accept),
    .busy_o       (trk_busy),
    .rsp          (rsp_if)
  );

  assign be_length_o    = job_q.length;
  assign be_src_addr_o  = job_q.src_addr;
  assign be_dst_addr_o  = job_q.dst_addr;
  assign be_opt_o       = job_q.opt;
  assign be_last_o      = (state_q == ISSUE) && (job_q.reps == rep_t'(1));
  assign busy_o         = (state_q == ISSUE) | trk_busy;
  assign nd_req_ready_o = nd_ready;

  always_comb begin
    state_d        = state_q;
    job_d          = job_q;
    nd_ready       = 1'b0;
    nd_hs          = 1'b0;
    be_req_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        // Held low during reset so every output shows its reset value.
        nd_ready = can_accept & ~rst_i;
        if (nd_req_valid_i && nd_ready) begin
          nd_hs            = 1'b1;
          job_d.length     = nd_length_i;
          job_d.src_addr   = nd_src_addr_i;
          job_d.dst_addr   = nd_dst_addr_i;
          job_d.src_stride = nd_src_stride_i;
          job_d.dst_stride = nd_dst_stride_i;
          job_d.reps       = (nd_reps_i == '0) ? rep_t'(1) : nd_reps_i;
          job_d.opt        = nd_opt_i;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        be_req_valid_o = 1'b1;
        if (be_req_ready_i) begin
          if (job_q.reps == rep_t'(1)) begin
            state_d = IDLE;
          end else begin
            job_d.src_addr = job_q.src_addr + job_q.src_stride;
            job_d.dst_addr = job_q.dst_addr + job_q.dst_stride;
            job_d.reps     = job_q.reps - rep_t'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      job_q   <= '0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
    end
  end
endmodule

// File: tb/tb_idma_2d_midend.sv
// tb/tb_idma_2d_midend.sv - self-checking bench for idma_2d_midend

module tb_idma_2d_midend;
  localparam int unsigned NumOut = 2;

  typedef struct {
    logic [31:0] len;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] ss;
    logic [31:0] ds;
    logic [31:0] reps;
    logic [63:0] opt;
  } job_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        nd_req_valid, nd_req_ready;
  logic [31:0] nd_length, nd_src_addr, nd_dst_addr, nd_src_stride, nd_dst_stride, nd_reps;
  logic [63:0] nd_opt;
  logic        be_req_valid, be_req_ready, be_last;
  logic [31:0] be_length, be_src_addr, be_dst_addr;
  logic [63:0] be_opt;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  idma_2d_midend_if rsp_bus ();

  always #5 clk = ~clk;

  idma_2d_midend #(
    .NumOutstanding (NumOut)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .nd_req_valid_i  (nd_req_valid),
    .nd_req_ready_o  (nd_req_ready),
    .nd_length_i     (nd_length),
    .nd_src_addr_i   (nd_src_addr),
    .nd_dst_addr_i   (nd_dst_addr),
    .nd_src_stride_i (nd_src_stride),
    .nd_dst_stride_i (nd_dst_stride),
    .nd_reps_i       (nd_reps),
    .nd_opt_i        (nd_opt),
    .be_req_valid_o  (be_req_valid),
    .be_req_ready_i  (be_req_ready),
    .be_length_o     (be_length),
    .be_src_addr_o   (be_src_addr),
    .be_dst_addr_o   (be_dst_addr),
    .be_opt_o        (be_opt),
    .be_last_o       (be_last),
    .be_rsp_valid_i  (rsp_bus.be_rsp_valid),
    .be_rsp_ready_o  (rsp_bus.be_rsp_ready),
    .be_rsp_error_i  (rsp_bus.be_rsp_error),
    .be_rsp_last_i   (rsp_bus.be_rsp_last),
    .nd_rsp_valid_o  (rsp_bus.nd_rsp_valid),
    .nd_rsp_ready_i  (rsp_bus.nd_rsp_ready),
    .nd_rsp_error_o  (rsp_bus.nd_rsp_error),
    .busy_o          (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbeats(input job_t j);
    return (j.reps == 0) ? 1 : int'(j.reps);
  endfunction

  task automatic submit(input job_t j);
    nd_length     = j.len;
    nd_src_addr   = j.src;
    nd_dst_addr   = j.dst;
    nd_src_stride = j.ss;
    nd_dst_stride = j.ds;
    nd_reps       = j.reps;
    nd_opt        = j.opt;
    nd_req_valid  = 1'b1;
    for (int c = 0; c < 50 && nd_req_ready !== 1'b1; c++) step();
    chk("nd_req_ready", 64'(nd_req_ready), 64'(1));
    step();
    nd_req_valid = 1'b0;
    chk("be_req_valid_latency", 64'(be_req_valid), 64'(1));
    chk("busy_issue", 64'(busy), 64'(1));
  endtask

  // Expected 1D addresses come straight from base + beat*stride modulo 2^32.
  task automatic collect(input job_t j, input int stall_at, input int stall_len, input bit rnd);
    int n;
    int beat;
    int guard;
    int stalled;
    logic        rdy;
    logic [31:0] es, ed;
    n = nbeats(j);
    beat = 0;
    guard = 0;
    stalled = 0;
    while (beat < n && guard < 500) begin
      if (beat == stall_at && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else if (rnd) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        rdy = 1'b1;
      end
      be_req_ready = rdy;
      es = j.src + j.ss * 32'(beat);
      ed = j.dst + j.ds * 32'(beat);
      chk("be_req_valid", 64'(be_req_valid), 64'(1));
      chk("be_src_addr", 64'(be_src_addr), 64'(es));
      chk("be_dst_addr", 64'(be_dst_addr), 64'(ed));
      chk("be_length", 64'(be_length), 64'(j.len));
      chk("be_opt", be_opt, j.opt);
      chk("be_last", 64'(be_last), 64'(beat == n - 1));
      step();
      if (rdy) beat++;
      guard++;
    end
    be_req_ready = 1'b0;
    chk("beat_count", 64'(beat), 64'(n));
    chk("no_extra_request", 64'(be_req_valid), 64'(0));
  endtask

  task automatic respond(input int n, input logic [31:0] errs);
    for (int i = 0; i < n; i++) begin
      rsp_bus.be_rsp_valid = 1'b1;
      rsp_bus.be_rsp_error = errs[i];
      rsp_bus.be_rsp_last  = (i == n - 1);
      chk("be_rsp_ready", 64'(rsp_bus.be_rsp_ready), 64'(1));
      step();
    end
    rsp_bus.be_rsp_valid = 1'b0;
    rsp_bus.be_rsp_error = 1'b0;
    rsp_bus.be_rsp_last  = 1'b0;
  endtask

  task automatic take(input logic exp_err);
    chk("nd_rsp_valid", 64'(rsp_bus.nd_rsp_valid), 64'(1));
    chk("nd_rsp_error", 64'(rsp_bus.nd_rsp_error), 64'(exp_err));
    chk("be_rsp_ready_blocked", 64'(rsp_bus.be_rsp_ready), 64'(0));
    rsp_bus.nd_rsp_ready = 1'b1;
    #1;
    chk("be_rsp_ready_passthru", 64'(rsp_bus.be_rsp_ready), 64'(1));
    step();
    rsp_bus.nd_rsp_ready = 1'b0;
    chk("nd_rsp_valid_drop", 64'(rsp_bus.nd_rsp_valid), 64'(0));
  endtask

  task automatic full_job(input job_t j, input logic [31:0] errs, input int stall_at,
                          input int stall_len, input bit rnd);
    int n;
    n = nbeats(j);
    submit(j);
    collect(j, stall_at, stall_len, rnd);
    respond(n, errs);
    take((errs & ((32'd1 << n) - 32'd1)) != 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_be_req_valid", 64'(be_req_valid), 64'(0));
    chk("rst_nd_req_ready", 64'(nd_req_ready), 64'(0));
    chk("rst_be_last", 64'(be_last), 64'(0));
    chk("rst_be_src", 64'(be_src_addr), 64'(0));
    chk("rst_be_dst", 64'(be_dst_addr), 64'(0));
    chk("rst_be_length", 64'(be_length), 64'(0));
    chk("rst_be_opt", be_opt, 64'(0));
    chk("rst_nd_rsp_valid", 64'(rsp_bus.nd_rsp_valid), 64'(0));
    chk("rst_nd_rsp_error", 64'(rsp_bus.nd_rsp_error), 64'(0));
    chk("rst_be_rsp_ready", 64'(rsp_bus.be_rsp_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t j, j1, j2, j3;

    rst = 1'b1;
    nd_req_valid = 1'b0;
    nd_length = '0; nd_src_addr = '0; nd_dst_addr = '0;
    nd_src_stride = '0; nd_dst_stride = '0; nd_reps = '0; nd_opt = '0;
    be_req_ready = 1'b0;
    rsp_bus.be_rsp_valid = 1'b0;
    rsp_bus.be_rsp_error = 1'b0;
    rsp_bus.be_rsp_last  = 1'b0;
    rsp_bus.nd_rsp_ready = 1'b0;
    step();
    step();
    check_reset_outputs();
    rst = 1'b0;
    step();
    chk("idle_nd_req_ready", 64'(nd_req_ready), 64'(1));

    // Basic 3-rep job, backend always ready
    j = '{len: 32'd64, src: 32'h1000, dst: 32'h8000, ss: 32'h100, ds: 32'h200,
          reps: 32'd3, opt: 64'hA5A5_0000_1234_5678};
    full_job(j, 32'b000, -1, 0, 1'b0);
    chk("idle_busy", 64'(busy), 64'(0));

    // reps = 0 behaves as a single request
    j = '{len: 32'd16, src: 32'h40, dst: 32'h80, ss: 32'h10, ds: 32'h20,
          reps: 32'd0, opt: 64'h1};
    full_job(j, 32'b0, -1, 0, 1'b0);

    // Address wrap, negative destination stride; error on a non-last response
    j = '{len: 32'd8, src: 32'hFFFF_FF00, dst: 32'h100, ss: 32'h200, ds: 32'hFFFF_FFF0,
          reps: 32'd2, opt: 64'hDEAD_BEEF};
    full_job(j, 32'b01, -1, 0, 1'b0);

    // Backend stalls 5 cycles mid-job
    j = '{len: 32'd128, src: 32'h2000, dst: 32'h3000, ss: 32'h80, ds: 32'h40,
          reps: 32'd4, opt: 64'h77};
    full_job(j, 32'b0, 2, 5, 1'b0);

    // Error in the middle response, then sticky must be clear for the next job
    j = '{len: 32'd4, src: 32'h10, dst: 32'h20, ss: 32'h4, ds: 32'h4,
          reps: 32'd3, opt: 64'h5};
    full_job(j, 32'b010, -1, 0, 1'b0);
    full_job(j, 32'b000, -1, 0, 1'b0);

    // Outstanding limit: two jobs in flight block the third
    j1 = '{len: 32'd1, src: 32'h100, dst: 32'h200, ss: 32'h0, ds: 32'h0,
           reps: 32'd1, opt: 64'h11};
    j2 = '{len: 32'd2, src: 32'h300, dst: 32'h400, ss: 32'h8, ds: 32'h8,
           reps: 32'd2, opt: 64'h22};
    j3 = '{len: 32'd3, src: 32'h500, dst: 32'h600, ss: 32'hC, ds: 32'hC,
           reps: 32'd1, opt: 64'h33};
    submit(j1);
    collect(j1, -1, 0, 1'b0);
    submit(j2);
    collect(j2, -1, 0, 1'b0);
    nd_req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("limit_nd_req_ready", 64'(nd_req_ready), 64'(0));
      chk("limit_busy", 64'(busy), 64'(1));
      step();
    end
    nd_req_valid = 1'b0;
    respond(1, 32'b0);
    chk("release_nd_req_ready", 64'(nd_req_ready), 64'(1));
    take(1'b0);
    submit(j3);
    collect(j3, -1, 0, 1'b0);
    respond(2, 32'b10);
    take(1'b1);
    respond(1, 32'b0);
    take(1'b0);
    chk("drain_busy", 64'(busy), 64'(0));

    // Randomized jobs against the address model
    for (int k = 0; k < 8; k++) begin
      j.len  = $urandom;
      j.src  = $urandom;
      j.dst  = $urandom;
      j.ss   = $urandom;
      j.ds   = $urandom;
      j.reps = $urandom_range(0, 5);
      j.opt  = {$urandom, $urandom};
      full_job(j, $urandom, -1, 0, 1'b1);
    end

    // Reset in the middle of a job
    j = '{len: 32'd32, src: 32'h9000, dst: 32'hA000, ss: 32'h20, ds: 32'h20,
          reps: 32'd4, opt: 64'hFF};
    submit(j);
    be_req_ready = 1'b1;
    step();
    be_req_ready = 1'b0;
    rst = 1'b1;
    step();
    check_reset_outputs();
    rst = 1'b0;
    step();
    chk("post_rst_nd_req_ready", 64'(nd_req_ready), 64'(1));
    j = '{len: 32'd12, src: 32'h44, dst: 32'h88, ss: 32'h100, ds: 32'h100,
          reps: 32'd2, opt: 64'hABC};
    full_job(j, 32'b10, -1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
